// File: rtl/exc_commit_ctrl_pkg.sv
// Shared definitions for the commit-point exception sequencer and the decode-stage priority selector.
package exc_commit_ctrl_pkg;

    localparam int EXC_W = 7;

    // Flag bit positions, order {int,adel,ades,sys,bp,ri,ov}; a higher index means a higher priority.
    localparam int EXC_OV   = 0;
    localparam int EXC_RI   = 1;
    localparam int EXC_BP   = 2;
    localparam int EXC_SYS  = 3;
    localparam int EXC_ADES = 4;
    localparam int EXC_ADEL = 5;
    localparam int EXC_INT  = 6;

    localparam logic [4:0] EXCCODE_INT  = 5'd0;
    localparam logic [4:0] EXCCODE_ADEL = 5'd4;
    localparam logic [4:0] EXCCODE_ADES = 5'd5;
    localparam logic [4:0] EXCCODE_SYS  = 5'd8;
    localparam logic [4:0] EXCCODE_BP   = 5'd9;
    localparam logic [4:0] EXCCODE_RI   = 5'd10;
    localparam logic [4:0] EXCCODE_OV   = 5'd12;

    localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2
    } exc_state_t;

endpackage

// File: rtl/exc_prio_sel.sv
// Fixed-priority one-hot selector: the highest set request bit wins.
module exc_prio_sel
    import exc_commit_ctrl_pkg::*;
#(
    parameter int W = EXC_W
) (
    input  logic [W-1:0] i_req,
    output logic [W-1:0] o_grant
);

    always_comb begin
        o_grant = '0;
        for (int i = 0; i < W; i++) begin
            if (i_req[i]) begin
                o_grant    = '0;
                o_grant[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/exc_commit_ctrl.sv
// Commit-point exception/interrupt sequencer: selects the committing event, pulses CP0,
// flushes the pipeline and holds a redirect to the vector or EPC until fetch accepts it.
module exc_commit_ctrl
    import exc_commit_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
    parameter int          EXC_W      = exc_commit_ctrl_pkg::EXC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_valid,
    input  logic [EXC_W-1:0] wb_exc,
    input  logic [31:0]      wb_pc,
    input  logic             wb_is_slot,
    input  logic             wb_eret,
    input  logic             wb_mtc0,
    input  logic [31:0]      wb_badvaddr,
    input  logic             int_happen,
    input  logic [31:0]      epc,
    output logic [EXC_W-1:0] cp0_exc_type,
    output logic [31:0]      cp0_pc,
    output logic             cp0_is_slot,
    output logic             cp0_eret,
    output logic             cp0_wen,
    output logic [31:0]      cp0_bad_vaddr,
    output logic             flush,
    output logic             commit_stall,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    input  logic             redirect_ready
);

    // state    | meaning
    // IDLE     | accepting commits
    // FLUSH    | squash IF..WB for one cycle
    // REDIRECT | hold redirect_pc until fetch accepts it
    exc_state_t r_state;
    logic       r_flush;
    logic       r_stall;
    logic       r_redirect_valid;
    logic [31:0] r_redirect_pc;

    logic             w_accept;
    logic [EXC_W-1:0] w_raw;
    logic [EXC_W-1:0] w_sel;
    logic             w_exc_any;

    // The int flag from WB is meaningless; the live interrupt comes from CP0.
    always_comb begin
        w_raw          = wb_exc;
        w_raw[EXC_INT] = int_happen;
    end

    exc_prio_sel #(.W(EXC_W)) u_prio_sel (
        .i_req   (w_raw),
        .o_grant (w_sel)
    );

    assign w_accept  = wb_valid && (r_state == ST_IDLE) && !rst;
    assign w_exc_any = |w_sel;

    assign cp0_exc_type  = w_accept ? w_sel : '0;
    assign cp0_eret      = w_accept && wb_eret && !w_exc_any;
    assign cp0_wen       = w_accept && wb_mtc0 && !w_exc_any;
    assign cp0_pc        = wb_pc;
    assign cp0_is_slot   = wb_is_slot;
    assign cp0_bad_vaddr = wb_badvaddr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= ST_IDLE;
            r_flush          <= 1'b0;
            r_stall          <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && (w_exc_any || wb_eret)) begin
                        r_state       <= ST_FLUSH;
                        r_flush       <= 1'b1;
                        r_stall       <= 1'b1;
                        r_redirect_pc <= w_exc_any ? EXC_VECTOR : epc;
                    end
                end
                ST_FLUSH: begin
                    r_state          <= ST_REDIRECT;
                    r_flush          <= 1'b0;
                    r_redirect_valid <= 1'b1;
                end
                ST_REDIRECT: begin
                    if (redirect_ready) begin
                        r_state          <= ST_IDLE;
                        r_stall          <= 1'b0;
                        r_redirect_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state          <= ST_IDLE;
                    r_flush          <= 1'b0;
                    r_stall          <= 1'b0;
                    r_redirect_valid <= 1'b0;
                end
            endcase
        end
    end

    assign flush          = r_flush;
    assign commit_stall   = r_stall;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Directed bench for exc_commit_ctrl: a vector table for single commits plus hand sequences
// for redirect back-pressure, commits during FLUSH/REDIRECT and reset mid-redirect.
module tb_exc_commit_ctrl;

    localparam logic [31:0] VEC = 32'hBFC0_0380;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid;
    logic [6:0]  wb_exc;
    logic [31:0] wb_pc;
    logic        wb_is_slot;
    logic        wb_eret;
    logic        wb_mtc0;
    logic [31:0] wb_badvaddr;
    logic        int_happen;
    logic [31:0] epc;
    logic [6:0]  cp0_exc_type;
    logic [31:0] cp0_pc;
    logic        cp0_is_slot;
    logic        cp0_eret;
    logic        cp0_wen;
    logic [31:0] cp0_bad_vaddr;
    logic        flush;
    logic        commit_stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    exc_commit_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .wb_valid       (wb_valid),
        .wb_exc         (wb_exc),
        .wb_pc          (wb_pc),
        .wb_is_slot     (wb_is_slot),
        .wb_eret        (wb_eret),
        .wb_mtc0        (wb_mtc0),
        .wb_badvaddr    (wb_badvaddr),
        .int_happen     (int_happen),
        .epc            (epc),
        .cp0_exc_type   (cp0_exc_type),
        .cp0_pc         (cp0_pc),
        .cp0_is_slot    (cp0_is_slot),
        .cp0_eret       (cp0_eret),
        .cp0_wen        (cp0_wen),
        .cp0_bad_vaddr  (cp0_bad_vaddr),
        .flush          (flush),
        .commit_stall   (commit_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready)
    );

    typedef struct {
        logic        valid;
        logic [6:0]  exc;
        logic        int_h;
        logic        eret;
        logic        mtc0;
        logic        slot;
        logic [31:0] pc;
        logic [31:0] badv;
        logic [31:0] epc_v;
        logic [6:0]  e_type;
        logic        e_eret;
        logic        e_wen;
        logic        e_redir;
        logic [31:0] e_rpc;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wb_valid    = 1'b0;
        wb_exc      = '0;
        wb_pc       = '0;
        wb_is_slot  = 1'b0;
        wb_eret     = 1'b0;
        wb_mtc0     = 1'b0;
        wb_badvaddr = '0;
    endtask

    // Applies one commit in IDLE, checks the accept-cycle pulse and, when expected, the full
    // flush -> redirect -> handshake sequence back to IDLE.
    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        wb_valid    = v.valid;
        wb_exc      = v.exc;
        int_happen  = v.int_h;
        wb_eret     = v.eret;
        wb_mtc0     = v.mtc0;
        wb_is_slot  = v.slot;
        wb_pc       = v.pc;
        wb_badvaddr = v.badv;
        epc         = v.epc_v;
        #1;
        chk({tag, ".exc_type"}, 32'(cp0_exc_type), 32'(v.e_type));
        chk({tag, ".eret"}, 32'(cp0_eret), 32'(v.e_eret));
        chk({tag, ".wen"}, 32'(cp0_wen), 32'(v.e_wen));
        chk({tag, ".pc"}, cp0_pc, v.pc);
        chk({tag, ".slot"}, 32'(cp0_is_slot), 32'(v.slot));
        chk({tag, ".badv"}, cp0_bad_vaddr, v.badv);
        @(posedge clk);
        #1;
        idle_inputs();
        int_happen = 1'b0;
        chk({tag, ".flush"}, 32'(flush), 32'(v.e_redir));
        chk({tag, ".stall1"}, 32'(commit_stall), 32'(v.e_redir));
        chk({tag, ".rv1"}, 32'(redirect_valid), 32'd0);
        if (v.e_redir) begin
            @(posedge clk);
            #1;
            chk({tag, ".flush2"}, 32'(flush), 32'd0);
            chk({tag, ".rv2"}, 32'(redirect_valid), 32'd1);
            chk({tag, ".rpc"}, redirect_pc, v.e_rpc);
            redirect_ready = 1'b1;
            @(posedge clk);
            #1;
            redirect_ready = 1'b0;
            chk({tag, ".rv3"}, 32'(redirect_valid), 32'd0);
            chk({tag, ".stall3"}, 32'(commit_stall), 32'd0);
        end
    endtask

    initial begin
        // valid exc int eret mtc0 slot pc badv epc | type eret wen redir rpc
        vecs[0]  = '{1'b1, 7'b0000011, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0100, 32'h0, 32'h0,
                     7'b0000010, 1'b0, 1'b0, 1'b1, VEC};
        vecs[1]  = '{1'b1, 7'b0100000, 1'b1, 1'b0, 1'b0, 1'b1, 32'h8000_0010, 32'h1234_5671, 32'h0,
                     7'b1000000, 1'b0, 1'b0, 1'b1, VEC};
        vecs[2]  = '{1'b1, 7'b0000000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8000_0200, 32'h0, 32'h8000_1234,
                     7'b0000000, 1'b1, 1'b0, 1'b1, 32'h8000_1234};
        vecs[3]  = '{1'b1, 7'b0001000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h8000_0300, 32'h0, 32'h0,
                     7'b0001000, 1'b0, 1'b0, 1'b1, VEC};
        vecs[4]  = '{1'b1, 7'b0000000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h8000_0304, 32'h0, 32'h0,
                     7'b0000000, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[5]  = '{1'b1, 7'b0010000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8000_0400, 32'hDEAD_BEEF, 32'h8000_5555,
                     7'b0010000, 1'b0, 1'b0, 1'b1, VEC};
        vecs[6]  = '{1'b1, 7'b0111111, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0500, 32'hCAFE_0002, 32'h0,
                     7'b0100000, 1'b0, 1'b0, 1'b1, VEC};
        vecs[7]  = '{1'b1, 7'b0000101, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_0600, 32'h0, 32'h0,
                     7'b0000100, 1'b0, 1'b0, 1'b1, VEC};
        vecs[8]  = '{1'b1, 7'b1000000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h8000_0700, 32'h0, 32'h0,
                     7'b0000000, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[9]  = '{1'b1, 7'b0000000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0800, 32'h0, 32'h0,
                     7'b0000000, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[10] = '{1'b0, 7'b0000001, 1'b0, 1'b1, 1'b1, 1'b0, 32'h8000_0900, 32'h0, 32'h0,
                     7'b0000000, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[11] = '{1'b1, 7'b0000110, 1'b0, 1'b0, 1'b1, 1'b0, 32'h8000_0A00, 32'h0, 32'h0,
                     7'b0000100, 1'b0, 1'b0, 1'b1, VEC};

        idle_inputs();
        int_happen     = 1'b0;
        epc            = '0;
        redirect_ready = 1'b0;
        rst            = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.flush", 32'(flush), 32'd0);
        chk("rst.stall", 32'(commit_stall), 32'd0);
        chk("rst.rv", 32'(redirect_valid), 32'd0);
        chk("rst.rpc", redirect_pc, 32'd0);
        chk("rst.type", 32'(cp0_exc_type), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // ERET with back-pressure, late EPC write, and commits offered while busy.
        @(negedge clk);
        wb_valid = 1'b1;
        wb_eret  = 1'b1;
        epc      = 32'h8000_1234;
        #1;
        chk("seqA.eret", 32'(cp0_eret), 32'd1);
        @(posedge clk);
        #1;
        chk("seqA.flush", 32'(flush), 32'd1);
        wb_eret    = 1'b0;
        wb_exc     = 7'b0000001;
        wb_mtc0    = 1'b1;
        int_happen = 1'b1;
        epc        = 32'h0BAD_0BAD;
        #1;
        chk("seqA.busy_type_f", 32'(cp0_exc_type), 32'd0);
        chk("seqA.busy_wen_f", 32'(cp0_wen), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("seqA.rv%0d", k), 32'(redirect_valid), 32'd1);
            chk($sformatf("seqA.rpc%0d", k), redirect_pc, 32'h8000_1234);
            chk($sformatf("seqA.stall%0d", k), 32'(commit_stall), 32'd1);
            chk($sformatf("seqA.flush%0d", k), 32'(flush), 32'd0);
            chk($sformatf("seqA.busy_type%0d", k), 32'(cp0_exc_type), 32'd0);
            chk($sformatf("seqA.busy_eret%0d", k), 32'(cp0_eret), 32'd0);
        end
        idle_inputs();
        redirect_ready = 1'b1;
        @(posedge clk);
        #1;
        redirect_ready = 1'b0;
        chk("seqA.rv_done", 32'(redirect_valid), 32'd0);
        chk("seqA.stall_done", 32'(commit_stall), 32'd0);
        // Interrupt left pending during the redirect is taken on the next commit.
        @(negedge clk);
        wb_valid = 1'b1;
        wb_pc    = 32'h8000_2000;
        #1;
        chk("seqA.int_taken", 32'(cp0_exc_type), 32'(7'b1000000));
        @(posedge clk);
        #1;
        idle_inputs();
        int_happen = 1'b0;
        chk("seqA.int_flush", 32'(flush), 32'd1);

        // Reset while in REDIRECT, then a normal commit.
        @(posedge clk);
        #1;
        chk("seqB.rv_pre", 32'(redirect_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("seqB.rv", 32'(redirect_valid), 32'd0);
        chk("seqB.stall", 32'(commit_stall), 32'd0);
        chk("seqB.flush", 32'(flush), 32'd0);
        chk("seqB.rpc", redirect_pc, 32'd0);
        chk("seqB.type", 32'(cp0_exc_type), 32'd0);
        run_vec(vecs[0], 100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
